dds_phase_gen_mc: RTL and testbench
===================================

Name: dds_phase_gen_mc

Overview:
- Multi-channel DDS phase generator, replacing the single-channel x-argument generator.
- Each channel has its own frequency-word accumulator and phase-offset load.
- Host writes go to shadow registers; one set_regs pulse commits all channels at the same time.
- Output phase words feed the polynomial sine/cosine evaluators, one per channel.

Parameters:
- DATA_WIDTH, 16: total width of the fixed-point phase/frequency word.
- F_width, 14: fractional bits; I_width = DATA_WIDTH-F_width integer bits.
- NUM_CH, 4: number of independent channels (1..16).
- CH_W, $clog2(NUM_CH) (min 1): width of the channel select.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  advance all accumulators this cycle.
- wr_en  in  1  shadow register write strobe.
- wr_sel  in  2  0=frequency, 1=phase offset, 2=sweep step (feature only), 3=reserved (ignored).
- wr_ch  in  CH_W  target channel; values >= NUM_CH are ignored.
- wr_data  in  DATA_WIDTH  write value, same I.F format.
- set_regs  in  1  commit all shadow registers to the active registers.
- phase_load  in  NUM_CH  per-channel select: load phase offset instead of accumulating.
- phase_o  out  NUM_CH*DATA_WIDTH  accumulator values; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- wrap_o  out  NUM_CH  per-channel one-cycle wrap pulse.
- valid_o  out  1  phase_o was updated in the previous cycle.

Behaviour:
- Modulus M = 2^(DATA_WIDTH-1).
  - The accumulator MSB is always forced to 0, so each phase_o word is in 0..M-1.
  - Loaded values and frequency values are also taken modulo M: the MSB is dropped.
- Reset (rst=0, asynchronous) clears all of the following: shadow and active freq/phase/step registers, accumulators, wrap_o, valid_o.
- Shadow write: on a clk edge with wr_en=1, shadow[wr_ch][wr_sel] <= wr_data.
  - The new value has no effect on the outputs until it is committed.
- Commit: on a clk edge with set_regs=1, every active register <= its shadow register.
  - All channels commit atomically.
  - If wr_en and set_regs are high in the same cycle, the commit takes the old shadow value; the newly written value lands in the shadow only.
- Accumulator update happens only on a clk edge with enable=1. For each channel k:
  - If phase_load[k]=1: acc[k] <= active_phase[k] mod M, and wrap_o[k] <= 0.
  - Otherwise: sum = acc[k] + active_freq[k] (DATA_WIDTH bits), acc[k] <= sum mod M, and wrap_o[k] <= (sum >= M).
- enable=0: accumulators hold, wrap_o <= 0, and phase_load is ignored.
- valid_o <= enable, registered.
- Latency:
  - One cycle from the enable edge to the updated phase_o.
  - A value committed by set_regs on edge N is first used on enable edge N+1.
  - If set_regs and enable are high on the same edge, the accumulate or load uses the pre-commit active values.
- Reset mid-operation immediately zeroes the outputs. After reset release, no output changes until the next enable edge.
- Frequency 0 holds the phase constant and never asserts wrap_o.

Optional Feature:
- Macro: DDS_FREQ_SWEEP_EN.
- When defined:
  - Adds a per-channel step register, written with wr_sel=2 and committed by set_regs.
  - On every enable edge, after active_freq[k] is used for the accumulation: active_freq[k] <= (active_freq[k] + active_step[k]) mod M.
  - A set_regs on the same edge takes priority and loads the shadow frequency instead.
- When undefined:
  - No step registers exist.
  - A write with wr_sel=2 is ignored.
  - active_freq changes only through set_regs.

Test Plan:
1. Reset with shadows written → phase_o=0, wrap_o=0, valid_o=0. After release plus 3 enable cycles, phase_o stays 0 because active_freq=0.
2. Write freq ch0=0x0100, set_regs, then 4 enable cycles → ch0 phase 0x0100, 0x0200, 0x0300, 0x0400; other channels remain 0; valid_o high one cycle behind each enable.
3. Freq ch2=0x4000 from acc=0 → ch2 goes 0x4000, then 0x0000 with wrap_o[2]=1 for exactly one cycle, then 0x4000 with wrap_o[2]=0.
4. Shadow isolation: active freq ch1=0x0010, write shadow freq ch1=0x0020 without set_regs → steps stay 0x0010. Pulse set_regs → the next enable step is 0x0020. wr_en and set_regs in the same cycle → the old shadow value is committed.
5. Phase load: write phase ch3=0x9234, set_regs, enable with phase_load=4'b1000 → ch3=0x1234 (MSB dropped) and wrap_o[3]=0, while ch0..2 accumulate normally. Same pulse with enable=0 → no change.
6. DDS_FREQ_SWEEP_EN, freq ch0=0x0100, step=0x0010 → phase_o ch0 is 0x0100, 0x0210, 0x0330 on successive enables. Build without the macro → wr_sel=2 has no effect.

Source files
------------

// File: rtl/dds_phase_gen_mc.sv
// Multi-channel DDS phase accumulator with shadow/active register banks and atomic commit.
// Latency 1 cycle enable->phase_o; no backpressure. Optional DDS_FREQ_SWEEP_EN adds per-channel frequency sweep.
module dds_phase_gen_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int F_width    = 14,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         wr_en,
    input  logic [1:0]                   wr_sel,
    input  logic [CH_W-1:0]              wr_ch,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    input  logic                         set_regs,
    input  logic [NUM_CH-1:0]            phase_load,
    output logic [NUM_CH*DATA_WIDTH-1:0] phase_o,
    output logic [NUM_CH-1:0]            wrap_o,
    output logic                         valid_o
);
    localparam int I_WIDTH = DATA_WIDTH - F_width;
    // Top integer bit is the wrap bit; everything below it is the modulo-M phase.
    localparam logic [DATA_WIDTH-1:0] MOD_MASK = {1'b0, {(I_WIDTH - 1 + F_width){1'b1}}};

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t             sh_freq_q   [NUM_CH];
    word_t             sh_phase_q  [NUM_CH];
    word_t             act_freq_q  [NUM_CH];
    word_t             act_phase_q [NUM_CH];
    word_t             acc_q       [NUM_CH];
    word_t             acc_d       [NUM_CH];
    word_t             sum_d       [NUM_CH];
    logic [NUM_CH-1:0] wrap_q, wrap_d;
    logic              valid_q;
    logic              wr_hit;
`ifdef DDS_FREQ_SWEEP_EN
    word_t             sh_step_q   [NUM_CH];
    word_t             act_step_q  [NUM_CH];
`endif

    assign wr_hit = wr_en && (int'(wr_ch) < NUM_CH);

    // Active registers are stored already reduced mod M, so the sum never exceeds 2M-2.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sum_d[k]  = acc_q[k] + act_freq_q[k];
            acc_d[k]  = acc_q[k];
            wrap_d[k] = 1'b0;
            if (enable) begin
                if (phase_load[k]) begin
                    acc_d[k] = act_phase_q[k];
                end else begin
                    acc_d[k]  = sum_d[k] & MOD_MASK;
                    wrap_d[k] = sum_d[k][DATA_WIDTH-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sh_freq_q[k]   <= '0;
                sh_phase_q[k]  <= '0;
                act_freq_q[k]  <= '0;
                act_phase_q[k] <= '0;
                acc_q[k]       <= '0;
`ifdef DDS_FREQ_SWEEP_EN
                sh_step_q[k]   <= '0;
                act_step_q[k]  <= '0;
`endif
            end
            wrap_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= enable;
            wrap_q  <= wrap_d;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k] <= acc_d[k];
                if (set_regs) begin
                    act_freq_q[k]  <= sh_freq_q[k] & MOD_MASK;
                    act_phase_q[k] <= sh_phase_q[k] & MOD_MASK;
`ifdef DDS_FREQ_SWEEP_EN
                    act_step_q[k]  <= sh_step_q[k] & MOD_MASK;
                end else if (enable) begin
                    act_freq_q[k]  <= (act_freq_q[k] + act_step_q[k]) & MOD_MASK;
`endif
                end
            end
            // Shadow write lands after the commit has sampled the old shadow value.
            if (wr_hit) begin
                case (wr_sel)
                    2'd0:    sh_freq_q[wr_ch]  <= wr_data;
                    2'd1:    sh_phase_q[wr_ch] <= wr_data;
`ifdef DDS_FREQ_SWEEP_EN
                    2'd2:    sh_step_q[wr_ch]  <= wr_data;
`endif
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign phase_o[g*DATA_WIDTH +: DATA_WIDTH] = acc_q[g];
    end

    assign wrap_o  = wrap_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_dds_phase_gen_mc.sv
// Directed bench for dds_phase_gen_mc with an arithmetic reference model checked every cycle.
module tb_dds_phase_gen_mc;
    localparam int DW = 16;
    localparam int NCH = 4;
    localparam int M = 1 << (DW - 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            wr_en;
    logic [1:0]      wr_sel;
    logic [1:0]      wr_ch;
    logic [DW-1:0]   wr_data;
    logic            set_regs;
    logic [NCH-1:0]  phase_load;
    logic [NCH*DW-1:0] phase_o;
    logic [NCH-1:0]  wrap_o;
    logic            valid_o;

    int n_chk = 0;
    int n_fail = 0;

    // Reference state as plain integers.
    int sf[NCH], sp[NCH], ss[NCH];
    int af[NCH], ap[NCH], as_[NCH];
    int acc[NCH];
    int wrp[NCH];
    int vld;

    dds_phase_gen_mc #(.DATA_WIDTH(DW), .F_width(14), .NUM_CH(NCH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_ch(wr_ch), .wr_data(wr_data), .set_regs(set_regs), .phase_load(phase_load),
        .phase_o(phase_o), .wrap_o(wrap_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_word(input int k);
        logic [NCH*DW-1:0] p;
        p = phase_o;
        return int'(p[k*DW +: DW]);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            sf[k] = 0; sp[k] = 0; ss[k] = 0;
            af[k] = 0; ap[k] = 0; as_[k] = 0;
            acc[k] = 0; wrp[k] = 0;
        end
        vld = 0;
    endfunction

    // Next state from the values present before the edge.
    function automatic void model_edge();
        for (int k = 0; k < NCH; k++) begin
            if (enable) begin
                if (phase_load[k]) begin
                    acc[k] = ap[k];
                    wrp[k] = 0;
                end else begin
                    wrp[k] = (acc[k] + af[k] >= M) ? 1 : 0;
                    acc[k] = (acc[k] + af[k]) % M;
                end
            end else begin
                wrp[k] = 0;
            end
            if (set_regs) begin
                af[k] = sf[k] % M;
                ap[k] = sp[k] % M;
                as_[k] = ss[k] % M;
            end
`ifdef DDS_FREQ_SWEEP_EN
            else if (enable) af[k] = (af[k] + as_[k]) % M;
`endif
        end
        if (wr_en && int'(wr_ch) < NCH) begin
            if (wr_sel == 2'd0) sf[wr_ch] = int'(wr_data);
            if (wr_sel == 2'd1) sp[wr_ch] = int'(wr_data);
`ifdef DDS_FREQ_SWEEP_EN
            if (wr_sel == 2'd2) ss[wr_ch] = int'(wr_data);
`endif
        end
        vld = enable ? 1 : 0;
    endfunction

    task automatic compare();
        int w;
        w = 0;
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("phase_ch%0d", k), dut_word(k), acc[k]);
            w |= wrp[k] << k;
        end
        check("wrap_o", int'(wrap_o), w);
        check("valid_o", int'(valid_o), vld);
    endtask

    task automatic cyc(input logic en, input logic [NCH-1:0] ld, input logic we,
                       input logic [1:0] sel, input logic [1:0] ch, input logic [DW-1:0] d,
                       input logic set);
        enable = en; phase_load = ld; wr_en = we; wr_sel = sel; wr_ch = ch;
        wr_data = d; set_regs = set;
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare();
        check("reset_wrap", int'(wrap_o), 0);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b0; enable = 0; wr_en = 0; wr_sel = 0; wr_ch = 0; wr_data = 0;
        set_regs = 0; phase_load = 0;
        model_reset();
        #3;
        compare();
        rst = 1'b1;

        // 1: shadow written, then reset clears it; enables keep phase at 0.
        cyc(0, 4'b0, 1, 2'd0, 2'd0, 16'h0777, 0);
        #2;
        do_reset();
        check("rst_ch0_lit", dut_word(0), 0);
        for (int i = 0; i < 3; i++) cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        cyc(0, 4'b0, 0, 2'd0, 2'd0, 16'h0, 1);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        check("t1_ch0_lit", dut_word(0), 0);

        // 2: ch0 frequency 0x0100.
        cyc(0, 4'b0, 1, 2'd0, 2'd0, 16'h0100, 0);
        cyc(0, 4'b0, 0, 2'd0, 2'd0, 16'h0, 1);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
            check("t2_ch0_lit", dut_word(0), i * 16'h0100);
            check("t2_ch1_lit", dut_word(1), 0);
        end
        cyc(0, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        check("t2_valid_low", int'(valid_o), 0);

        // 3: ch2 wraps at half scale.
        cyc(0, 4'b0, 1, 2'd0, 2'd2, 16'h4000, 0);
        cyc(0, 4'b0, 0, 2'd0, 2'd0, 16'h0, 1);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        check("t3_ch2_a", dut_word(2), 16'h4000);
        check("t3_wrap_a", int'(wrap_o[2]), 0);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        check("t3_ch2_b", dut_word(2), 0);
        check("t3_wrap_b", int'(wrap_o[2]), 1);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        check("t3_ch2_c", dut_word(2), 16'h4000);
        check("t3_wrap_c", int'(wrap_o[2]), 0);

        // 4: shadow isolation and same-cycle write+commit.
        cyc(0, 4'b0, 1, 2'd0, 2'd1, 16'h0010, 0);
        cyc(0, 4'b0, 0, 2'd0, 2'd0, 16'h0, 1);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        cyc(0, 4'b0, 1, 2'd0, 2'd1, 16'h0020, 0);
        for (int i = 0; i < 2; i++) cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        check("t4_ch1_lit", dut_word(1), 16'h0030);
        cyc(0, 4'b0, 0, 2'd0, 2'd0, 16'h0, 1);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        check("t4_ch1_commit", dut_word(1), 16'h0050);
        cyc(0, 4'b0, 1, 2'd0, 2'd1, 16'h0070, 1);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        check("t4_ch1_oldshadow", dut_word(1), 16'h0070);
        cyc(0, 4'b0, 0, 2'd0, 2'd0, 16'h0, 1);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        cyc(0, 4'b0, 1, 2'd3, 2'd1, 16'h1111, 1);
        cyc(0, 4'b0, 1, 2'd0, 2'd3, 16'hFFFF, 1);
        for (int i = 0; i < 3; i++) cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);

        // 5: phase load with MSB dropped.
        cyc(0, 4'b0, 1, 2'd1, 2'd3, 16'h9234, 0);
        cyc(0, 4'b0, 0, 2'd0, 2'd0, 16'h0, 1);
        cyc(1, 4'b1000, 0, 2'd0, 2'd0, 16'h0, 0);
        check("t5_ch3_load", dut_word(3), 16'h1234);
        check("t5_wrap3", int'(wrap_o[3]), 0);
        cyc(0, 4'b1000, 0, 2'd0, 2'd0, 16'h0, 0);
        check("t5_ch3_hold", dut_word(3), 16'h1234);
        cyc(0, 4'b0, 1, 2'd1, 2'd3, 16'h0055, 0);
        cyc(1, 4'b1000, 0, 2'd0, 2'd0, 16'h0, 1);
        check("t5_ch3_precommit", dut_word(3), 16'h1234);
        cyc(1, 4'b1000, 0, 2'd0, 2'd0, 16'h0, 0);
        check("t5_ch3_postcommit", dut_word(3), 16'h0055);

        // 6: frequency sweep (or its absence).
        #2;
        do_reset();
        cyc(0, 4'b0, 1, 2'd0, 2'd0, 16'h0100, 0);
        cyc(0, 4'b0, 1, 2'd2, 2'd0, 16'h0010, 0);
        cyc(0, 4'b0, 0, 2'd0, 2'd0, 16'h0, 1);
`ifdef DDS_FREQ_SWEEP_EN
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0); check("t6_s1", dut_word(0), 16'h0100);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0); check("t6_s2", dut_word(0), 16'h0210);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0); check("t6_s3", dut_word(0), 16'h0330);
`else
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0); check("t6_s1", dut_word(0), 16'h0100);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0); check("t6_s2", dut_word(0), 16'h0200);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0); check("t6_s3", dut_word(0), 16'h0300);
`endif

        // Mid-operation reset, then no change until the next enable edge.
        enable = 1'b1;
        #2;
        do_reset();
        check("midrst_ch0", dut_word(0), 0);
        cyc(0, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);
        cyc(1, 4'b0, 0, 2'd0, 2'd0, 16'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
